bandpass_decim: RTL and testbench
=================================

Name: bandpass_decim

Overview:
- Downstream stage of bandpass_fir: consumes the filter's signed DATA_W+GAIN_W-bit output stream (valid_in/data_in).
- Integrate-and-dump decimation by DEC.
- Requantizes the dump by right shift with round-half-up, then saturates to OUT_W bits.
- Emits one output strobe per DEC accepted samples and feeds the rate-reduced back end.

Parameters:
- IN_W, 20, input width; equals bandpass_fir DATA_W+GAIN_W (16+4).
- DEC, 4, decimation factor; power of two, 2..256.
- LOG2_DEC, 2, log2(DEC); accumulator width ACC_W = IN_W+LOG2_DEC.
- OUT_W, 16, output width.
- SHIFT, 6, right shift applied to the dump; 0..ACC_W-1.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- clr  input  1  synchronous frame restart
- valid_in  input  1  data_in valid this cycle
- data_in  input  IN_W  signed two's-complement sample from bandpass_fir
- valid_out  output  1  one-cycle strobe, data_out/sat_out new
- data_out  output  OUT_W  signed decimated sample, held between strobes
- sat_out  output  1  data_out was clipped; updated with each strobe

Behaviour:
- Reset (rst low, asynchronous): acc=0, phase=0, valid_out=0, data_out=0, sat_out=0. State stays held while rst is low. Reset mid-frame discards the partial sum.
- State: phase counter 0..DEC-1 and signed ACC_W accumulator.
- Accept: a sample is accepted on an edge with rst high, clr low and valid_in high. Gaps in valid_in are allowed; they do not advance phase or alter acc.
- Non-final accept (phase<DEC-1): acc <= acc + sext(data_in); phase <= phase+1.
- Final accept (phase==DEC-1):
  - sum = acc + sext(data_in), computed combinationally.
  - r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. Evaluate in ACC_W+1 bits so there is no wrap. Arithmetic shift, so rounding is half toward +inf.
  - If r > 2^(OUT_W-1)-1: data_out <= max positive, sat_out <= 1.
  - If r < -2^(OUT_W-1): data_out <= max negative, sat_out <= 1.
  - Otherwise data_out <= r[OUT_W-1:0], sat_out <= 0.
  - valid_out <= 1; acc <= 0; phase <= 0.
- Latency: valid_out is high for exactly the one cycle after the edge that accepted the DEC-th sample. Back-to-back frames give strobes DEC cycles apart.
- valid_out <= 0 on every edge that is not a final accept.
- clr high: acc <= 0, phase <= 0, valid_out <= 0. Any valid_in in the same cycle is dropped; clr has priority. data_out and sat_out keep their last values.
- The accumulator never overflows: ACC_W bits hold DEC full-scale samples exactly.
- No backpressure. The consumer must take each strobe.

Test Plan:
- Reset: hold rst low 2 cycles with valid_in=1, data_in=100 -> valid_out=0, data_out=0, sat_out=0 throughout. No strobe within 3 cycles after release unless 4 samples are accepted.
- Basic: defaults, 4 consecutive samples of 100 -> sum 400, (400+32)>>>6=6. valid_out pulses once, exactly 1 cycle after the 4th sample edge. data_out=6, sat_out=0.
- Saturation: 4 samples of 524287 -> r=32768 -> data_out=32767, sat_out=1. Then 4 samples of -524288 -> r=-32768 -> data_out=-32768, sat_out=0.
- Rounding and gaps: samples 16,16,0,0 with 2 idle cycles between each -> sum 32, r=1. Strobe follows the 4th valid sample only. Samples -32,0,0,0 -> r=0; -33,0,0,0 -> r=-1.
- clr mid-frame: 2 samples of 1000, then clr with valid_in=1 and data_in=5000 (dropped), then 4 samples of 64 -> single strobe, data_out=4. No strobe from the aborted frame.
- Async reset mid-frame: 3 samples of 2000, assert rst asynchronously between edges -> outputs 0 immediately. After release, 4 samples of 128 -> data_out=8.

Source files
------------

// File: rtl/bandpass_decim.sv
// Integrate-and-dump decimator behind bandpass_fir: sums DEC accepted samples,
// rounds half-up by SHIFT bits and saturates the result to OUT_W bits.
`timescale 1ns/1ps
module bandpass_decim #(
  parameter int IN_W     = 20,
  parameter int DEC      = 4,
  parameter int LOG2_DEC = 2,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    valid_in,
  input  logic signed [IN_W-1:0]  data_in,
  output logic                    valid_out,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    sat_out
);

  // Handshake: valid-only, no ready. A sample is taken on any edge with
  // valid_in high and clr low; valid_out is a one-cycle strobe the consumer
  // must take, and data_out/sat_out hold until the next strobe.

  localparam int ACC_W = IN_W + LOG2_DEC;
  localparam int SUM_W = ACC_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam longint RND_I = (SHIFT > 0) ? (longint'(1) << RND_SH) : longint'(0);
  localparam longint MAXP_I = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint MAXN_I = -(longint'(1) << (OUT_W - 1));
  localparam logic signed [SUM_W-1:0] RND  = SUM_W'(RND_I);
  localparam logic signed [SUM_W-1:0] MAXP = SUM_W'(MAXP_I);
  localparam logic signed [SUM_W-1:0] MAXN = SUM_W'(MAXN_I);
  localparam logic [LOG2_DEC-1:0] LAST = LOG2_DEC'(DEC - 1);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_DEC-1:0]      phase_q, phase_d;
  logic                     valid_q, valid_d;
  logic signed [OUT_W-1:0]  data_q, data_d;
  logic                     sat_q, sat_d;

  logic                     accept;
  logic                     final_acc;
  logic signed [ACC_W-1:0]  din_ext;
  logic signed [SUM_W-1:0]  sum_w;
  logic signed [SUM_W-1:0]  rnd_w;
  logic signed [SUM_W-1:0]  r_w;

  assign accept    = valid_in && !clr;
  assign final_acc = accept && (phase_q == LAST);
  assign din_ext   = {{LOG2_DEC{data_in[IN_W-1]}}, data_in};

  // One guard bit above the accumulator so the rounding add cannot wrap.
  assign sum_w = {acc_q[ACC_W-1], acc_q} + {din_ext[ACC_W-1], din_ext};
  assign rnd_w = sum_w + RND;
  assign r_w   = rnd_w >>> SHIFT;

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    valid_d = 1'b0;
    data_d  = data_q;
    sat_d   = sat_q;
    if (clr) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (final_acc) begin
      acc_d   = '0;
      phase_d = '0;
      valid_d = 1'b1;
      if (r_w > MAXP) begin
        data_d = OUT_W'(MAXP_I);
        sat_d  = 1'b1;
      end else if (r_w < MAXN) begin
        data_d = OUT_W'(MAXN_I);
        sat_d  = 1'b1;
      end else begin
        data_d = r_w[OUT_W-1:0];
        sat_d  = 1'b0;
      end
    end else if (accept) begin
      acc_d   = acc_q + din_ext;
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sat_out   = sat_q;

endmodule

// File: tb/tb_bandpass_decim.sv
// Directed bench for bandpass_decim: a reference model pushes expected dumps
// and their strobe cycle into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_bandpass_decim;

  localparam int IN_W  = 20;
  localparam int OUT_W = 16;

  logic                    clk;
  logic                    rst;
  logic                    clr;
  logic                    valid_in;
  logic signed [IN_W-1:0]  data_in;
  logic                    valid_out;
  logic signed [OUT_W-1:0] data_out;
  logic                    sat_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [OUT_W:0] exp_q[$];
  int             exp_cyc_q[$];

  longint m_acc = 0;
  int     m_phase = 0;
  logic [OUT_W:0] last_exp = '0;

  bandpass_decim dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sat_out   (sat_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && valid_out) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe cyc=%0d data=%0d sat=%0b expected no strobe", cyc, data_out, sat_out);
      end
      if (exp_q.size() != 0) begin
        logic [OUT_W:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        checks++;
        assert ({sat_out, data_out} === e) else begin
          errors++;
          $error("FAIL dump_value got data=%0d sat=%0b expected data=%0d sat=%0b",
                 data_out, sat_out, $signed(e[OUT_W-1:0]), e[OUT_W]);
        end
        checks++;
        assert (cyc === ec) else begin
          errors++;
          $error("FAIL strobe_latency got cycle %0d expected cycle %0d", cyc, ec);
        end
      end
    end
  end

  // driver tasks
  task automatic send(input int d);
    longint sum, r;
    logic [OUT_W-1:0] dv;
    logic sv;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = IN_W'(d);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (m_phase == 3) begin
      sum = m_acc + longint'(d);
      r   = (sum + 32) >>> 6;
      if (r > 32767) begin
        dv = 16'h7fff; sv = 1'b1;
      end else if (r < -32768) begin
        dv = 16'h8000; sv = 1'b1;
      end else begin
        dv = r[OUT_W-1:0]; sv = 1'b0;
      end
      exp_q.push_back({sv, dv});
      exp_cyc_q.push_back(cyc);
      last_exp = {sv, dv};
      m_acc = 0;
      m_phase = 0;
    end else begin
      m_acc = m_acc + longint'(d);
      m_phase++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [OUT_W+1:0] exp_v);
    checks++;
    assert ({valid_out, sat_out, data_out} === exp_v) else begin
      errors++;
      $error("FAIL %s got valid=%0b sat=%0b data=%0d expected valid=%0b sat=%0b data=%0d",
             tag, valid_out, sat_out, data_out, exp_v[OUT_W+1], exp_v[OUT_W],
             $signed(exp_v[OUT_W-1:0]));
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    idle(3);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_missing_strobe got %0d pending expected 0", tag, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; valid_in = 1'b1; data_in = 20'sd100;
    // reset held with traffic present
    @(negedge clk); check_out("reset_c1", '0);
    @(negedge clk); check_out("reset_c2", '0);
    valid_in = 1'b0;
    rst = 1'b1;
    idle(3);
    check_out("post_reset_idle", '0);

    // basic
    repeat (4) send(100);
    drain("basic");
    check_out("basic_hold", {1'b0, last_exp});

    // saturation both ways
    repeat (4) send(524287);
    drain("sat_pos");
    repeat (4) send(-524288);
    drain("sat_neg");

    // rounding with gaps
    send(16); idle(2); send(16); idle(2); send(0); idle(2); send(0);
    drain("gaps");
    send(-32); send(0); send(0); send(0);
    drain("round_zero");
    send(-33); send(0); send(0); send(0);
    drain("round_neg");

    // clr mid-frame drops concurrent sample and keeps outputs
    send(1000); send(1000);
    @(negedge clk);
    clr = 1'b1; valid_in = 1'b1; data_in = 20'sd5000;
    @(posedge clk); #1;
    clr = 1'b0; valid_in = 1'b0;
    m_acc = 0; m_phase = 0;
    check_out("clr_hold", {1'b0, last_exp});
    repeat (4) send(64);
    drain("clr");

    // async reset mid-frame
    repeat (3) send(2000);
    #3;
    rst = 1'b0;
    #1;
    check_out("async_reset", '0);
    m_acc = 0; m_phase = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) send(128);
    drain("after_reset");

    // random back-to-back frames
    for (int f = 0; f < 6; f++) begin
      repeat (4) send(int'($urandom_range(0, 1048575)) - 524288);
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
